// File: rtl/fifo_1r1w_counted_if.sv
// Producer/consumer handshake, flush and status bundle for fifo_1r1w_counted.
// The FIFO attaches through the slave modport; the surrounding logic through master.
interface fifo_1r1w_counted_if #(
    parameter int width_p = 32,
    parameter int depth_p = 16
);
    localparam int cnt_w = $clog2(depth_p + 1);

    // ready/valid in: a word moves when valid_i & ready_o at a rising edge.
    // valid/yumi out: the head moves when yumi_i & valid_o; yumi_i alone is ignored.
    logic               flush_i;
    logic [width_p-1:0] data_i;
    logic               valid_i;
    logic               ready_o;
    logic               valid_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic [cnt_w-1:0]   count_o;
    logic               almost_full_o;
    logic               almost_empty_o;

    modport slave (
        input  flush_i, data_i, valid_i, yumi_i,
        output ready_o, valid_o, data_o, count_o, almost_full_o, almost_empty_o
    );

    modport master (
        output flush_i, data_i, valid_i, yumi_i,
        input  ready_o, valid_o, data_o, count_o, almost_full_o, almost_empty_o
    );
endinterface

// File: rtl/fifo_1r1w_counted.sv
// Full-throughput 1R1W FIFO of any depth >= 2 over a synchronous-read memory,
// with occupancy count, almost-full/almost-empty flags and synchronous flush.
module fifo_1r1w_counted #(
    parameter int width_p        = 32,
    parameter int depth_p        = 16,
    parameter int almost_full_p  = 14,
    parameter int almost_empty_p = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    fifo_1r1w_counted_if.slave    io
);
    localparam int cnt_w = $clog2(depth_p + 1);
    localparam int ptr_w = $clog2(depth_p);

    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(depth_p - 1);
    localparam logic [cnt_w-1:0] depth_c  = cnt_w'(depth_p);
    localparam logic [cnt_w-1:0] af_c     = cnt_w'(almost_full_p);
    localparam logic [cnt_w-1:0] ae_c     = cnt_w'(almost_empty_p);

    logic [ptr_w-1:0]   wr_ptr, rd_ptr;
    logic [ptr_w-1:0]   wr_ptr_inc, rd_ptr_inc, rd_addr;
    logic [cnt_w-1:0]   count;
    logic               pending;
    logic               ready, valid, enq, deq, accept;
    logic [width_p-1:0] mem [depth_p];
    logic [width_p-1:0] rd_data;

    // pending marks a word written at the last edge; the memory read that
    // happened at that same edge could not see it, so it is not yet visible.
    assign ready  = (count < depth_c);
    assign valid  = (count > cnt_w'(pending));
    assign enq    = io.valid_i & ready;
    assign deq    = io.yumi_i & valid;
    assign accept = reset_ni & ~io.flush_i;

    assign wr_ptr_inc = (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_inc = (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;

    // Look one entry ahead while dequeuing so data_o advances every cycle.
    assign rd_addr = deq ? rd_ptr_inc : rd_ptr;

    always_ff @(posedge clk_i) begin
        if (!reset_ni || io.flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr_inc;
            if (deq) rd_ptr <= rd_ptr_inc;
            count   <= count + cnt_w'(enq) - cnt_w'(deq);
            pending <= enq;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq && accept) mem[wr_ptr] <= io.data_i;
        rd_data <= mem[rd_addr];
    end

    assign io.ready_o        = ready;
    assign io.valid_o        = valid;
    assign io.data_o         = rd_data;
    assign io.count_o        = count;
    assign io.almost_full_o  = (count >= af_c);
    assign io.almost_empty_o = (count <= ae_c);
endmodule

// File: tb/tb_fifo_1r1w_counted.sv
// Bench for fifo_1r1w_counted (depth 5, almost-full 4, almost-empty 1):
// directed vector table, streaming wrap sequence, then random traffic against a queue model.
module tb_fifo_1r1w_counted;
    localparam int W     = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic reset_n;

    fifo_1r1w_counted_if #(.width_p(W), .depth_p(DEPTH)) bus ();

    fifo_1r1w_counted #(
        .width_p(W), .depth_p(DEPTH), .almost_full_p(AF), .almost_empty_p(AE)
    ) dut (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .io      (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: stored words with the cycle they were enqueued in.
    typedef struct {
        logic [W-1:0] data;
        int           t;
    } ent_t;
    ent_t q[$];
    int   cyc   = 0;
    bit   known = 0;

    function automatic bit m_valid();
        return (q.size() > 0) && (q[0].t + 2 <= cyc);
    endfunction

    task automatic apply(input logic r, input logic f, input logic v,
                         input logic [W-1:0] d, input logic y);
        reset_n     = r;
        bus.flush_i = f;
        bus.valid_i = v;
        bus.data_i  = d;
        bus.yumi_i  = y;
    endtask

    task automatic check_model();
        int n;
        if (!known) return;
        n = q.size();
        check("m_count", 32'(bus.count_o), 32'(n));
        check("m_ready", 32'(bus.ready_o), 32'(n < DEPTH));
        check("m_valid", 32'(bus.valid_o), 32'(m_valid()));
        check("m_afull", 32'(bus.almost_full_o), 32'(n >= AF));
        check("m_aempty", 32'(bus.almost_empty_o), 32'(n <= AE));
        if (m_valid()) check("m_data", 32'(bus.data_o), 32'(q[0].data));
    endtask

    task automatic tick();
        bit   mv, en, de;
        ent_t e;
        mv = m_valid();
        en = bus.valid_i && (q.size() < DEPTH);
        de = bus.yumi_i && mv;
        @(posedge clk);
        if (!reset_n) begin
            q.delete();
            known = 1;
        end else if (bus.flush_i) begin
            q.delete();
        end else begin
            if (de) void'(q.pop_front());
            if (en) begin
                e.data = bus.data_i;
                e.t    = cyc;
                q.push_back(e);
            end
        end
        cyc++;
        #1;
    endtask

    typedef struct {
        logic         rst_n, flush, vin;
        logic [W-1:0] din;
        logic         yumi, chk;
        logic         e_ready, e_valid;
        logic [W-1:0] e_data;
        logic [2:0]   e_count;
        logic         e_af, e_ae;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic f, logic v, logic [W-1:0] d, logic y, logic c,
                                logic rdy, logic val, logic [W-1:0] dat, logic [2:0] cnt,
                                logic af, logic ae);
        vec_t x;
        x.rst_n = r; x.flush = f; x.vin = v; x.din = d; x.yumi = y; x.chk = c;
        x.e_ready = rdy; x.e_valid = val; x.e_data = dat; x.e_count = cnt;
        x.e_af = af; x.e_ae = ae;
        return x;
    endfunction

    initial begin
        apply(1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Outputs listed are those expected in the cycle the row's inputs are applied.
        //             rst  fl   v    din    y    chk  rdy  val  data   cnt  af   ae
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 1));
        // fill 1..5, then drain with continuous yumi
        tbl.push_back(mk(1, 0, 1, 8'h01, 0, 1, 1, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8'h02, 0, 1, 1, 0, 8'h00, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8'h03, 0, 1, 1, 1, 8'h01, 2, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'h04, 0, 1, 1, 1, 8'h01, 3, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'h05, 0, 1, 1, 1, 8'h01, 4, 1, 0));
        tbl.push_back(mk(1, 0, 1, 8'h66, 1, 1, 0, 1, 8'h01, 5, 1, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h02, 4, 1, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h03, 3, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h04, 2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h05, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 1));
        // single word latency with yumi held high
        tbl.push_back(mk(1, 0, 1, 8'hAB, 1, 1, 1, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'hAB, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 1));
        // flush with a concurrent enqueue and dequeue
        tbl.push_back(mk(1, 0, 1, 8'h11, 0, 1, 1, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8'h22, 0, 1, 1, 0, 8'h00, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8'h33, 0, 1, 1, 1, 8'h11, 2, 0, 0));
        tbl.push_back(mk(1, 1, 1, 8'h77, 1, 1, 1, 1, 8'h11, 3, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'h88, 0, 1, 1, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h88, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 1));
        // same again with reset instead of flush
        tbl.push_back(mk(1, 0, 1, 8'h11, 0, 1, 1, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8'h22, 0, 1, 1, 0, 8'h00, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8'h33, 0, 1, 1, 1, 8'h11, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h77, 1, 1, 1, 1, 8'h11, 3, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'h88, 0, 1, 1, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 1, 8'h88, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 1));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst_n, tbl[i].flush, tbl[i].vin, tbl[i].din, tbl[i].yumi);
            check_model();
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_ready", i), 32'(bus.ready_o), 32'(tbl[i].e_ready));
                check($sformatf("tbl%0d_valid", i), 32'(bus.valid_o), 32'(tbl[i].e_valid));
                check($sformatf("tbl%0d_count", i), 32'(bus.count_o), 32'(tbl[i].e_count));
                check($sformatf("tbl%0d_afull", i), 32'(bus.almost_full_o), 32'(tbl[i].e_af));
                check($sformatf("tbl%0d_aempty", i), 32'(bus.almost_empty_o), 32'(tbl[i].e_ae));
                if (tbl[i].e_valid)
                    check($sformatf("tbl%0d_data", i), 32'(bus.data_o), 32'(tbl[i].e_data));
            end
            tick();
        end

        // Streaming across the pointer wrap: 23 words in and out back to back.
        for (int i = 0; i < 26; i++) begin
            int exp_cnt;
            apply(1'b1, 1'b0, i < 23, W'(i), 1'b1);
            check_model();
            exp_cnt = (i == 0) ? 0 : (i == 1) ? 1 : (i <= 23) ? 2 : (i == 24) ? 1 : 0;
            check($sformatf("stream%0d_valid", i), 32'(bus.valid_o), 32'(i >= 2 && i <= 24));
            check($sformatf("stream%0d_count", i), 32'(bus.count_o), 32'(exp_cnt));
            if (i >= 2 && i <= 24)
                check($sformatf("stream%0d_data", i), 32'(bus.data_o), 32'(i - 2));
            tick();
        end

        // Random traffic: first phase leans toward filling, second toward draining.
        for (int i = 0; i < 600; i++) begin
            logic v, y, f, r;
            v = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            y = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 59) == 0);
            r = ($urandom_range(0, 89) != 0);
            apply(r, f, v, W'($urandom_range(0, 255)), y);
            check_model();
            tick();
        end

        apply(1'b1, 1'b0, 1'b0, '0, 1'b0);
        check_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
